mux2_rr_arbiter: RTL and testbench

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

---
 rtl/mux2_rr_arbiter_pkg.sv | 14 +
 rtl/MUX2D4.sv | 17 +
 rtl/mux2_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-input round-robin packet arbiter.
// Holds the FSM state encoding and the default payload width. The block
// and its bench both import this package.
package mux2_rr_arbiter_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/MUX2D4.sv
// Behavioural model of the MUX2D4 library cell.
// One-bit 2:1 mux.
// Ports:
//   I0 - data input selected when S=0
//   I1 - data input selected when S=1
//   S  - select
//   Z  - output
module MUX2D4 (
    input  logic I0,
    input  logic I1,
    input  logic S,
    output logic Z
);

    assign Z = S ? I1 : I0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin packet arbiter with a registered output stage.
// Once the first beat of a multi-beat packet is accepted, the winner holds
// the grant until its last beat is accepted. Packets therefore never
// interleave on the output.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | between packets; round-robin choice among the valid requesters
// LOCK0 | mid-packet from requester 0; only requester 0 may be granted
// LOCK1 | mid-packet from requester 1; only requester 1 may be granted
//
// Ports:
//   nvdla_core_clk    - core clock
//   nvdla_core_rstn   - asynchronous active-low reset
//   in0_pvld/prdy     - requester-0 valid/ready handshake
//   in0_pd/plast      - requester-0 payload and last-beat flag
//   in1_pvld/prdy     - requester-1 valid/ready handshake
//   in1_pd/plast      - requester-1 payload and last-beat flag
//   out_pvld/prdy     - output valid/ready handshake
//   out_pd/plast      - registered payload and last-beat flag
//   out_sel           - source requester of the beat held in the output register
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          in0_pvld,
    output logic          in0_prdy,
    input  logic [DW-1:0] in0_pd,
    input  logic          in0_plast,
    input  logic          in1_pvld,
    output logic          in1_prdy,
    input  logic [DW-1:0] in1_pd,
    input  logic          in1_plast,
    output logic          out_pvld,
    input  logic          out_prdy,
    output logic [DW-1:0] out_pd,
    output logic          out_plast,
    output logic          out_sel
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          last_gnt;
    logic          last_gnt_nxt;
    logic          gnt_0;
    logic          gnt_1;
    logic          pipe_en;
    logic          acc_0;
    logic          acc_1;
    logic          acc;
    logic          mux_plast;
    logic [DW-1:0] mux_pd;

    assign pipe_en = !out_pvld || out_prdy;

    // Gate ready with reset so neither requester sees a handshake while the
    // block is held in reset (the output stage is empty, so pipe_en is 1).
    assign in0_prdy = nvdla_core_rstn && pipe_en && gnt_0;
    assign in1_prdy = nvdla_core_rstn && pipe_en && gnt_1;

    assign acc_0 = in0_pvld && in0_prdy;
    assign acc_1 = in1_pvld && in1_prdy;
    assign acc   = acc_0 || acc_1;

    assign mux_plast = gnt_1 ? in1_plast : in0_plast;

    for (genvar i = 0; i < DW; i++) begin : g_pd_mux
        MUX2D4 u_mux (
            .I0 (in0_pd[i]),
            .I1 (in1_pd[i]),
            .S  (gnt_1),
            .Z  (mux_pd[i])
        );
    end

    // Grant decode. On a tie in IDLE the requester that did not win the
    // previous packet goes first.
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        case (state)
            IDLE: begin
                gnt_0 = in0_pvld && (!in1_pvld || last_gnt);
                gnt_1 = in1_pvld && (!in0_pvld || !last_gnt);
            end
            LOCK0:   gnt_0 = 1'b1;
            LOCK1:   gnt_1 = 1'b1;
            default: ;
        endcase
    end

    // Next state. Acceptances only happen with pipe_en=1, so a stalled
    // output freezes both the state and the round-robin pointer.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (acc) begin
                    last_gnt_nxt = acc_1;
                    if (!mux_plast) begin
                        state_nxt = acc_1 ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0: begin
                if (acc_0 && in0_plast) begin
                    state_nxt = IDLE;
                end
            end
            LOCK1: begin
                if (acc_1 && in1_plast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_pvld  <= 1'b0;
            out_plast <= 1'b0;
            out_sel   <= 1'b0;
        end else if (pipe_en) begin
            out_pvld <= acc;
            if (acc) begin
                out_plast <= mux_plast;
                out_sel   <= gnt_1;
            end
        end
    end

    // Payload register carries no reset; it is only meaningful with out_pvld=1.
    always_ff @(posedge nvdla_core_clk) begin
        if (acc) begin
            out_pd <= mux_pd;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;
    import mux2_rr_arbiter_pkg::*;

    localparam int DW = DW_DEFAULT;

    logic          clk;
    logic          rstn;
    logic          in0_pvld;
    logic          in0_prdy;
    logic [DW-1:0] in0_pd;
    logic          in0_plast;
    logic          in1_pvld;
    logic          in1_prdy;
    logic [DW-1:0] in1_pd;
    logic          in1_plast;
    logic          out_pvld;
    logic          out_prdy;
    logic [DW-1:0] out_pd;
    logic          out_plast;
    logic          out_sel;

    int errors = 0;
    int checks = 0;

    mux2_rr_arbiter #(.DW(DW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .in0_pvld        (in0_pvld),
        .in0_prdy        (in0_prdy),
        .in0_pd          (in0_pd),
        .in0_plast       (in0_plast),
        .in1_pvld        (in1_pvld),
        .in1_prdy        (in1_prdy),
        .in1_pd          (in1_pd),
        .in1_plast       (in1_plast),
        .out_pvld        (out_pvld),
        .out_prdy        (out_prdy),
        .out_pd          (out_pd),
        .out_plast       (out_plast),
        .out_sel         (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in0_pvld  = 1'b0;
        in0_pd    = '0;
        in0_plast = 1'b0;
        in1_pvld  = 1'b0;
        in1_pd    = '0;
        in1_plast = 1'b0;
        out_prdy  = 1'b1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        in0_pvld = 1'b1;
        in1_pvld = 1'b1;
        tick();
        checks++;
        if (in0_prdy !== 1'b0 || in1_prdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_prdy: got in0_prdy=%b in1_prdy=%b, want 0 0", in0_prdy, in1_prdy);
        end
        checks++;
        if (out_pvld !== 1'b0 || out_plast !== 1'b0 || out_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got pvld=%b plast=%b sel=%b, want 0 0 0", out_pvld, out_plast, out_sel);
        end
        tick();
        rstn = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        in0_pvld  = 1'b1;
        in0_pd    = DW'(32'hA5);
        in0_plast = 1'b1;
        #1;
        checks++;
        if (in0_prdy !== 1'b1 || in1_prdy !== 1'b0) begin
            errors++;
            $display("FAIL single_prdy: got in0_prdy=%b in1_prdy=%b, want 1 0", in0_prdy, in1_prdy);
        end
        tick();
        in0_pvld = 1'b0;
        checks++;
        if (out_pvld !== 1'b1 || out_pd !== DW'(32'hA5) || out_sel !== 1'b0 || out_plast !== 1'b1) begin
            errors++;
            $display("FAIL single_out: got pvld=%b pd=%h sel=%b plast=%b, want 1 a5 0 1", out_pvld, out_pd, out_sel, out_plast);
        end
        tick();
        checks++;
        if (out_pvld !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got out_pvld=%b, want 0", out_pvld);
        end
    endtask

    task automatic test_alternate();
        apply_reset();
        in0_pvld  = 1'b1;
        in1_pvld  = 1'b1;
        in0_plast = 1'b1;
        in1_plast = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit exp_sel;
            logic [DW-1:0] exp_pd;
            exp_sel = (i % 2) == 1;
            in0_pd  = DW'(32'h100 + i);
            in1_pd  = DW'(32'h200 + i);
            exp_pd  = exp_sel ? DW'(32'h200 + i) : DW'(32'h100 + i);
            #1;
            checks++;
            if (in0_prdy !== !exp_sel || in1_prdy !== exp_sel) begin
                errors++;
                $display("FAIL alt_prdy[%0d]: got in0_prdy=%b in1_prdy=%b, want winner %0d", i, in0_prdy, in1_prdy, exp_sel);
            end
            tick();
            checks++;
            if (out_pvld !== 1'b1 || out_sel !== exp_sel || out_pd !== exp_pd) begin
                errors++;
                $display("FAIL alt_out[%0d]: got pvld=%b sel=%b pd=%h, want 1 %0d %h", i, out_pvld, out_sel, out_pd, exp_sel, exp_pd);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock();
        apply_reset();
        in1_pvld  = 1'b1;
        in1_pd    = DW'(32'h1);
        in1_plast = 1'b0;
        tick();
        checks++;
        if (out_pvld !== 1'b1 || out_sel !== 1'b1 || out_pd !== DW'(32'h1)) begin
            errors++;
            $display("FAIL lock_beat1: got pvld=%b sel=%b pd=%h, want 1 1 1", out_pvld, out_sel, out_pd);
        end
        in0_pvld  = 1'b1;
        in0_pd    = DW'(32'hC0);
        in0_plast = 1'b1;
        in1_pd    = DW'(32'h2);
        #1;
        checks++;
        if (in0_prdy !== 1'b0 || in1_prdy !== 1'b1) begin
            errors++;
            $display("FAIL lock_prdy2: got in0_prdy=%b in1_prdy=%b, want 0 1", in0_prdy, in1_prdy);
        end
        tick();
        checks++;
        if (out_pvld !== 1'b1 || out_sel !== 1'b1 || out_pd !== DW'(32'h2) || out_plast !== 1'b0) begin
            errors++;
            $display("FAIL lock_beat2: got pvld=%b sel=%b pd=%h plast=%b, want 1 1 2 0", out_pvld, out_sel, out_pd, out_plast);
        end
        // requester 1 pauses mid-packet; requester 0 must still be blocked
        in1_pvld = 1'b0;
        #1;
        checks++;
        if (in0_prdy !== 1'b0) begin
            errors++;
            $display("FAIL lock_gap_prdy: got in0_prdy=%b, want 0", in0_prdy);
        end
        tick();
        checks++;
        if (out_pvld !== 1'b0) begin
            errors++;
            $display("FAIL lock_gap_out: got out_pvld=%b, want 0", out_pvld);
        end
        in1_pvld  = 1'b1;
        in1_pd    = DW'(32'h3);
        in1_plast = 1'b1;
        #1;
        checks++;
        if (in0_prdy !== 1'b0 || in1_prdy !== 1'b1) begin
            errors++;
            $display("FAIL lock_prdy3: got in0_prdy=%b in1_prdy=%b, want 0 1", in0_prdy, in1_prdy);
        end
        tick();
        checks++;
        if (out_pvld !== 1'b1 || out_sel !== 1'b1 || out_pd !== DW'(32'h3) || out_plast !== 1'b1) begin
            errors++;
            $display("FAIL lock_beat3: got pvld=%b sel=%b pd=%h plast=%b, want 1 1 3 1", out_pvld, out_sel, out_pd, out_plast);
        end
        in1_pvld = 1'b0;
        tick();
        checks++;
        if (out_pvld !== 1'b1 || out_sel !== 1'b0 || out_pd !== DW'(32'hC0)) begin
            errors++;
            $display("FAIL lock_after: got pvld=%b sel=%b pd=%h, want 1 0 c0", out_pvld, out_sel, out_pd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        in0_pvld  = 1'b1;
        in1_pvld  = 1'b1;
        in0_plast = 1'b1;
        in1_plast = 1'b1;
        in0_pd    = DW'(32'h50);
        in1_pd    = DW'(32'h60);
        tick();
        checks++;
        if (out_pvld !== 1'b1 || out_sel !== 1'b0 || out_pd !== DW'(32'h50)) begin
            errors++;
            $display("FAIL bp_first: got pvld=%b sel=%b pd=%h, want 1 0 50", out_pvld, out_sel, out_pd);
        end
        out_prdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in0_pd = DW'(32'h70 + i);
            in1_pd = DW'(32'h80 + i);
            #1;
            checks++;
            if (in0_prdy !== 1'b0 || in1_prdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_prdy[%0d]: got in0_prdy=%b in1_prdy=%b, want 0 0", i, in0_prdy, in1_prdy);
            end
            tick();
            checks++;
            if (out_pvld !== 1'b1 || out_sel !== 1'b0 || out_pd !== DW'(32'h50)) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got pvld=%b sel=%b pd=%h, want 1 0 50", i, out_pvld, out_sel, out_pd);
            end
        end
        out_prdy = 1'b1;
        in1_pd   = DW'(32'h99);
        #1;
        checks++;
        if (in0_prdy !== 1'b0 || in1_prdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume_prdy: got in0_prdy=%b in1_prdy=%b, want 0 1", in0_prdy, in1_prdy);
        end
        tick();
        checks++;
        if (out_pvld !== 1'b1 || out_sel !== 1'b1 || out_pd !== DW'(32'h99)) begin
            errors++;
            $display("FAIL bp_resume_out: got pvld=%b sel=%b pd=%h, want 1 1 99", out_pvld, out_sel, out_pd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_lock();
        apply_reset();
        in1_pvld  = 1'b1;
        in1_pd    = DW'(32'h1);
        in1_plast = 1'b0;
        tick();
        checks++;
        if (out_pvld !== 1'b1 || out_sel !== 1'b1) begin
            errors++;
            $display("FAIL rml_beat1: got pvld=%b sel=%b, want 1 1", out_pvld, out_sel);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (out_pvld !== 1'b0 || in0_prdy !== 1'b0 || in1_prdy !== 1'b0) begin
            errors++;
            $display("FAIL rml_async: got pvld=%b in0_prdy=%b in1_prdy=%b, want 0 0 0", out_pvld, in0_prdy, in1_prdy);
        end
        in0_pvld  = 1'b1;
        in0_pd    = DW'(32'hD0);
        in0_plast = 1'b1;
        in1_pd    = DW'(32'hE0);
        in1_plast = 1'b1;
        #2;
        rstn = 1'b1;
        #1;
        checks++;
        if (in0_prdy !== 1'b1 || in1_prdy !== 1'b0) begin
            errors++;
            $display("FAIL rml_first_grant: got in0_prdy=%b in1_prdy=%b, want 1 0", in0_prdy, in1_prdy);
        end
        tick();
        checks++;
        if (out_pvld !== 1'b1 || out_sel !== 1'b0 || out_pd !== DW'(32'hD0)) begin
            errors++;
            $display("FAIL rml_out: got pvld=%b sel=%b pd=%h, want 1 0 d0", out_pvld, out_sel, out_pd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [15:0]   seq [2];
        logic [15:0]   exp_seq [2];
        int            len [2];
        int            idx [2];
        bit            hold [2];
        bit            open;
        bit            open_sel;
        bit            a0;
        bit            a1;
        logic [DW-1:0] q_pd [$];
        bit            q_last [$];
        bit            q_sel [$];
        logic [DW-1:0] e_pd;
        bit            e_last;
        bit            e_sel;

        apply_reset();
        open     = 1'b0;
        open_sel = 1'b0;
        for (int r = 0; r < 2; r++) begin
            seq[r]     = '0;
            exp_seq[r] = '0;
            len[r]     = $urandom_range(1, 4);
            idx[r]     = 0;
            hold[r]    = 1'b0;
        end

        for (int cyc = 0; cyc < 460; cyc++) begin
            bit feed;
            feed = cyc < 400;
            for (int r = 0; r < 2; r++) begin
                if (!hold[r] && feed) hold[r] = ($urandom_range(0, 3) != 0);
            end
            in0_pvld  = hold[0];
            in0_pd    = DW'({16'h0000, seq[0]});
            in0_plast = (idx[0] == len[0] - 1);
            in1_pvld  = hold[1];
            in1_pd    = DW'({16'h0001, seq[1]});
            in1_plast = (idx[1] == len[1] - 1);
            out_prdy  = feed ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            checks++;
            if (in0_prdy && in1_prdy) begin
                errors++;
                $display("FAIL rnd_both_prdy[%0d]: got in0_prdy=1 in1_prdy=1, want at most one", cyc);
            end
            a0 = in0_pvld && in0_prdy;
            a1 = in1_pvld && in1_prdy;

            if (out_pvld && out_prdy) begin
                checks++;
                if (q_pd.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra[%0d]: got beat pd=%h sel=%b, want none pending", cyc, out_pd, out_sel);
                end else begin
                    e_pd   = q_pd.pop_front();
                    e_last = q_last.pop_front();
                    e_sel  = q_sel.pop_front();
                    if (out_pd !== e_pd || out_plast !== e_last || out_sel !== e_sel) begin
                        errors++;
                        $display("FAIL rnd_beat[%0d]: got pd=%h plast=%b sel=%b, want %h %b %b", cyc, out_pd, out_plast, out_sel, e_pd, e_last, e_sel);
                    end
                end
                checks++;
                if (out_pd[16] !== out_sel || out_pd[15:0] !== exp_seq[out_sel]) begin
                    errors++;
                    $display("FAIL rnd_seq[%0d]: got pd=%h sel=%b, want seq %h", cyc, out_pd, out_sel, exp_seq[out_sel]);
                end
                exp_seq[out_sel] = exp_seq[out_sel] + 16'd1;
                checks++;
                if (open && out_sel !== open_sel) begin
                    errors++;
                    $display("FAIL rnd_interleave[%0d]: got sel=%b, want %b until packet end", cyc, out_sel, open_sel);
                end
                open     = !out_plast;
                open_sel = out_sel;
            end

            if (a0) begin
                q_pd.push_back(in0_pd);
                q_last.push_back(in0_plast);
                q_sel.push_back(1'b0);
            end
            if (a1) begin
                q_pd.push_back(in1_pd);
                q_last.push_back(in1_plast);
                q_sel.push_back(1'b1);
            end
            for (int r = 0; r < 2; r++) begin
                if ((r == 0 && a0) || (r == 1 && a1)) begin
                    hold[r] = 1'b0;
                    seq[r]  = seq[r] + 16'd1;
                    if (idx[r] == len[r] - 1) begin
                        idx[r] = 0;
                        len[r] = $urandom_range(1, 4);
                    end else begin
                        idx[r]++;
                    end
                end
            end
            tick();
        end

        checks++;
        if (q_pd.size() != 0 || out_pvld !== 1'b0) begin
            errors++;
            $display("FAIL rnd_drain: got %0d pending beats, out_pvld=%b, want 0 0", q_pd.size(), out_pvld);
        end
        checks++;
        if (exp_seq[0] !== seq[0] || exp_seq[1] !== seq[1]) begin
            errors++;
            $display("FAIL rnd_count: got out %0d/%0d beats, want %0d/%0d", exp_seq[0], exp_seq[1], seq[0], seq[1]);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_backpressure();
        test_reset_mid_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
